// File: rtl/leds_pkg.sv
// Shared types and constants for the LED driver: state encoding, LED count and the
// legal ranges of the top-level parameters.
package leds_pkg;

  typedef enum logic [1:0] {
    RST,
    LAMP,
    RUN
  } state_e;

  localparam int unsigned LED_COUNT       = 8;
  localparam int unsigned LAMP_CYCLES_MAX = 255;
  localparam int unsigned PWM_BITS_MIN    = 1;
  localparam int unsigned PWM_BITS_MAX    = 8;

endpackage

// File: rtl/leds_if.sv
// Internal bus between the LED state machine and the PWM generator, plus an
// observation view of the registered LED vector.
interface leds_if;
  import leds_pkg::*;

  logic                 en;
  logic                 pwm_on;
  logic [LED_COUNT-1:0] led;

  modport master (output en, input pwm_on, output led);
  modport slave  (input en, output pwm_on);
  modport mon    (input led);

endinterface

// File: rtl/leds_pwm.sv
// PWM counter and duty compare. The counter is held at 0 while disabled and runs
// freely (wrapping) while enabled; pwm_on reflects the current counter value.
module leds_pwm
  import leds_pkg::*;
#(
  parameter int unsigned PWM_BITS = 4,
  parameter int unsigned DUTY     = 16
) (
  input  logic   CLK,
  input  logic   RST_N,
  leds_if.slave  bus
);

  // One extra bit so that DUTY = 2^PWM_BITS is representable.
  localparam logic [PWM_BITS:0]   DutyW = (PWM_BITS + 1)'(DUTY);
  localparam logic [PWM_BITS-1:0] One   = PWM_BITS'(1);

  logic [PWM_BITS-1:0] cnt_q = '0;
  logic [PWM_BITS-1:0] cnt_d;

  always_comb begin
    cnt_d = '0;
    if (bus.en) begin
      cnt_d = cnt_q + One;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.pwm_on = ({1'b0, cnt_q} < DutyW);

endmodule

// File: rtl/leds.sv
// LED driver: after reset, a lamp test lights every LED for LAMP_CYCLES cycles, then
// the PATTERN mask is shown gated by a PWM duty cycle. All outputs are registered.
module leds
  import leds_pkg::*;
#(
  parameter logic [LED_COUNT-1:0] PATTERN     = 8'h01,
  parameter int unsigned          LAMP_CYCLES = 8,
  parameter int unsigned          PWM_BITS    = 4,
  parameter int unsigned          DUTY        = 16
) (
  input  logic CLK,
  input  logic RST_N,
  output logic LED0,
  output logic LED1,
  output logic LED2,
  output logic LED3,
  output logic LED4,
  output logic LED5,
  output logic LED6,
  output logic LED7
);

  if (LAMP_CYCLES > LAMP_CYCLES_MAX) begin : g_bad_lamp
    $error("leds: LAMP_CYCLES out of range 0..255");
  end
  if (PWM_BITS < PWM_BITS_MIN || PWM_BITS > PWM_BITS_MAX) begin : g_bad_bits
    $error("leds: PWM_BITS out of range 1..8");
  end
  if (DUTY > (1 << PWM_BITS)) begin : g_bad_duty
    $error("leds: DUTY exceeds 2^PWM_BITS");
  end

  localparam bit        LampEn   = (LAMP_CYCLES != 0);
  localparam logic [7:0] LampLast = 8'(LAMP_CYCLES - 1);

  state_e               state_q = RST;
  state_e               state_d;
  logic [7:0]           lamp_q  = '0;
  logic [7:0]           lamp_d;
  logic [LED_COUNT-1:0] led_q   = '0;
  logic [LED_COUNT-1:0] led_d;

  leds_if u_if ();

  leds_pwm #(
    .PWM_BITS (PWM_BITS),
    .DUTY     (DUTY)
  ) u_pwm (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (u_if)
  );

  always_comb begin
    state_d = state_q;
    lamp_d  = lamp_q;
    unique case (state_q)
      RST:  state_d = LampEn ? LAMP : RUN;
      LAMP: begin
        if (lamp_q == LampLast) begin
          state_d = RUN;
        end
        // Saturate so the counter can never wrap back to a lamp-test value.
        lamp_d = (lamp_q == 8'hFF) ? lamp_q : lamp_q + 8'd1;
      end
      RUN:     state_d = RUN;
      default: state_d = RST;
    endcase

    // Outputs follow the state being entered, so LEDs change on the transition edge.
    led_d = '0;
    unique case (state_d)
      LAMP:    led_d = '1;
      RUN:     led_d = u_if.pwm_on ? PATTERN : '0;
      default: led_d = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= RST;
      lamp_q  <= '0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      lamp_q  <= lamp_d;
      led_q   <= led_d;
    end
  end

  // The PWM counter advances during the cycle before each RUN edge, so RUN entry uses count 0.
  assign u_if.en  = (state_d == RUN);
  assign u_if.led = led_q;

  assign {LED7, LED6, LED5, LED4, LED3, LED2, LED1, LED0} = led_q;

endmodule

// File: tb/tb_leds.sv
// Directed bench for leds: four instances with different parameter sets share one
// clock and reset; LED vectors are checked against hand-derived sequences.
module tb_leds;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  logic [7:0] l0, l1, l2, l3;

  leds_if m0 ();
  leds_if m1 ();
  leds_if m2 ();
  leds_if m3 ();

  assign m0.led = l0;
  assign m1.led = l1;
  assign m2.led = l2;
  assign m3.led = l3;

  // Defaults.
  leds u_d0 (
    .CLK (clk), .RST_N (rst_n),
    .LED0 (l0[0]), .LED1 (l0[1]), .LED2 (l0[2]), .LED3 (l0[3]),
    .LED4 (l0[4]), .LED5 (l0[5]), .LED6 (l0[6]), .LED7 (l0[7])
  );

  // No lamp test.
  leds #(.LAMP_CYCLES (0)) u_d1 (
    .CLK (clk), .RST_N (rst_n),
    .LED0 (l1[0]), .LED1 (l1[1]), .LED2 (l1[2]), .LED3 (l1[3]),
    .LED4 (l1[4]), .LED5 (l1[5]), .LED6 (l1[6]), .LED7 (l1[7])
  );

  // 1-in-4 duty on a 2-bit counter.
  leds #(.PATTERN (8'hA5), .PWM_BITS (2), .DUTY (1)) u_d2 (
    .CLK (clk), .RST_N (rst_n),
    .LED0 (l2[0]), .LED1 (l2[1]), .LED2 (l2[2]), .LED3 (l2[3]),
    .LED4 (l2[4]), .LED5 (l2[5]), .LED6 (l2[6]), .LED7 (l2[7])
  );

  // Zero duty: dark after the lamp test.
  leds #(.PATTERN (8'hFF), .DUTY (0)) u_d3 (
    .CLK (clk), .RST_N (rst_n),
    .LED0 (l3[0]), .LED1 (l3[1]), .LED2 (l3[2]), .LED3 (l3[3]),
    .LED4 (l3[4]), .LED5 (l3[5]), .LED6 (l3[6]), .LED7 (l3[7])
  );

  int tests = 0;
  int fails = 0;

  // k = clock edges since reset release (0 = reset held).
  function automatic logic [7:0] exp_led(input int d, input int k);
    logic [7:0] e;
    e = 8'h00;
    if (k > 0) begin
      case (d)
        0: e = (k <= 8) ? 8'hFF : 8'h01;
        1: e = 8'h01;
        2: e = (k <= 8) ? 8'hFF : (((k - 9) % 4 == 0) ? 8'hA5 : 8'h00);
        default: e = (k <= 8) ? 8'hFF : 8'h00;
      endcase
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string phase, input int k);
    chk($sformatf("%s d0 k=%0d", phase, k), m0.led, exp_led(0, k));
    chk($sformatf("%s d1 k=%0d", phase, k), m1.led, exp_led(1, k));
    chk($sformatf("%s d2 k=%0d", phase, k), m2.led, exp_led(2, k));
    chk($sformatf("%s d3 k=%0d", phase, k), m3.led, exp_led(3, k));
  endtask

  initial begin
    #1;
    check_all("power-up", 0);

    repeat (3) begin
      @(negedge clk);
      check_all("reset", 0);
    end
    rst_n = 1'b1;

    // Lamp test, PWM pattern and a long RUN stretch across many counter wraps.
    for (int k = 1; k <= 1100; k++) begin
      @(negedge clk);
      check_all("run", k);
    end

    // Fresh reset, then interrupt the lamp test at its 4th cycle.
    rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_all("rst2", 0);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check_all("lamp-part", k);
    end
    rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_all("mid-lamp-rst", 0);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      check_all("restart", k);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
